// File: rtl/alu_pkg.sv
// alu_pkg: shared constants and types for the mips_alu execute-stage ALU.
//   - FN_* : R-type funct field encodings
//   - OP_* : opcode field encodings
//   - alu_op_e     : internal decoded operation
//   - shift_mode_e : barrel shifter mode (logical left / logical right / arithmetic right)
//   - alu_decode() : maps {opcode, funct} onto alu_op_e
package alu_pkg;

    // R-type funct codes
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    typedef enum logic [4:0] {
        ALU_NOP, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLLV, ALU_SRLV, ALU_SRAV,
        ALU_ADD, ALU_ADDU, ALU_SUB, ALU_SUBU,
        ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU,
        ALU_ADDI, ALU_ADDIU, ALU_SLTI, ALU_SLTIU,
        ALU_ANDI, ALU_ORI, ALU_XORI, ALU_LUI
    } alu_op_e;

    typedef enum logic [1:0] {
        SH_LL = 2'd0,
        SH_RL = 2'd1,
        SH_RA = 2'd2
    } shift_mode_e;

    // Unknown encodings decode to ALU_NOP, which produces a zero result.
    function automatic alu_op_e alu_decode(input logic [5:0] opcode, input logic [5:0] funct);
        alu_op_e op;
        op = ALU_NOP;
        if (opcode == OP_RTYPE) begin
            case (funct)
                FN_SLL:  op = ALU_SLL;
                FN_SRL:  op = ALU_SRL;
                FN_SRA:  op = ALU_SRA;
                FN_SLLV: op = ALU_SLLV;
                FN_SRLV: op = ALU_SRLV;
                FN_SRAV: op = ALU_SRAV;
                FN_ADD:  op = ALU_ADD;
                FN_ADDU: op = ALU_ADDU;
                FN_SUB:  op = ALU_SUB;
                FN_SUBU: op = ALU_SUBU;
                FN_AND:  op = ALU_AND;
                FN_OR:   op = ALU_OR;
                FN_XOR:  op = ALU_XOR;
                FN_NOR:  op = ALU_NOR;
                FN_SLT:  op = ALU_SLT;
                FN_SLTU: op = ALU_SLTU;
                default: op = ALU_NOP;
            endcase
        end else begin
            case (opcode)
                OP_ADDI:  op = ALU_ADDI;
                OP_ADDIU: op = ALU_ADDIU;
                OP_SLTI:  op = ALU_SLTI;
                OP_SLTIU: op = ALU_SLTIU;
                OP_ANDI:  op = ALU_ANDI;
                OP_ORI:   op = ALU_ORI;
                OP_XORI:  op = ALU_XORI;
                OP_LUI:   op = ALU_LUI;
                default:  op = ALU_NOP;
            endcase
        end
        return op;
    endfunction

endpackage

// File: rtl/alu_shifter.sv
// alu_shifter: combinational barrel shifter.
//   value_i  : operand to shift
//   amount_i : shift distance 0..31
//   mode_i   : SH_LL logical left, SH_RL logical right, SH_RA arithmetic right
//   result_o : shifted value
module alu_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value_i,
    input  logic [4:0]       amount_i,
    input  shift_mode_e      mode_i,
    output logic [WIDTH-1:0] result_o
);

    // Select shift direction/type.
    always_comb begin
        result_o = value_i;
        case (mode_i)
            SH_LL:   result_o = value_i << amount_i;
            SH_RL:   result_o = value_i >> amount_i;
            SH_RA:   result_o = $unsigned($signed(value_i) >>> amount_i);
            default: result_o = value_i;
        endcase
    end

endmodule

// File: rtl/mips_alu.sv
// mips_alu: 32-bit MIPS-style integer ALU with registered result and flags.
//   clk, rst_n : clock, asynchronous active-low reset
//   opcode     : 0 selects R-type (decoded by funct), else I-type
//   funct      : R-type function field
//   inp1, inp2 : operands (rs, rt); I-type immediate is inp2[15:0]
//   shamt      : constant shift amount
//   out        : result, one cycle after inputs are sampled
//   zero       : result == 0
//   overflow   : signed overflow of add/sub/addi only
module mips_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] inp1,
    input  logic [WIDTH-1:0] inp2,
    input  logic [4:0]       shamt,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    alu_op_e          op_s;
    logic [WIDTH-1:0] imm_se_s, imm_ze_s;
    logic [WIDTH-1:0] sum_s, diff_s, sumi_s, shift_res_s;
    logic [4:0]       sh_amt_s;
    shift_mode_e      sh_mode_s;
    logic [WIDTH-1:0] result_d;
    logic             ovf_d;
    logic [WIDTH-1:0] out_q;
    logic             zero_q, ovf_q;

    assign op_s     = alu_decode(opcode, funct);
    assign imm_se_s = {{(WIDTH-16){inp2[15]}}, inp2[15:0]};
    assign imm_ze_s = {{(WIDTH-16){1'b0}}, inp2[15:0]};
    assign sum_s    = inp1 + inp2;
    assign diff_s   = inp1 - inp2;
    assign sumi_s   = inp1 + imm_se_s;

    // Shared shifter: pick constant vs. variable amount and the shift mode.
    always_comb begin
        sh_amt_s  = shamt;
        sh_mode_s = SH_LL;
        case (op_s)
            ALU_SLL:  begin sh_amt_s = shamt;     sh_mode_s = SH_LL; end
            ALU_SRL:  begin sh_amt_s = shamt;     sh_mode_s = SH_RL; end
            ALU_SRA:  begin sh_amt_s = shamt;     sh_mode_s = SH_RA; end
            ALU_SLLV: begin sh_amt_s = inp1[4:0]; sh_mode_s = SH_LL; end
            ALU_SRLV: begin sh_amt_s = inp1[4:0]; sh_mode_s = SH_RL; end
            ALU_SRAV: begin sh_amt_s = inp1[4:0]; sh_mode_s = SH_RA; end
            default:  begin sh_amt_s = shamt;     sh_mode_s = SH_LL; end
        endcase
    end

    alu_shifter #(.WIDTH(WIDTH)) u_shifter (
        .value_i  (inp2),
        .amount_i (sh_amt_s),
        .mode_i   (sh_mode_s),
        .result_o (shift_res_s)
    );

    // Result mux and overflow. Overflow: operands effectively share a sign
    // that differs from the result sign (for sub, B's sign is inverted).
    always_comb begin
        result_d = '0;
        ovf_d    = 1'b0;
        case (op_s)
            ALU_SLL, ALU_SRL, ALU_SRA,
            ALU_SLLV, ALU_SRLV, ALU_SRAV: result_d = shift_res_s;
            ALU_ADD: begin
                result_d = sum_s;
                ovf_d    = (inp1[WIDTH-1] == inp2[WIDTH-1]) && (sum_s[WIDTH-1] != inp1[WIDTH-1]);
            end
            ALU_ADDU: result_d = sum_s;
            ALU_SUB: begin
                result_d = diff_s;
                ovf_d    = (inp1[WIDTH-1] != inp2[WIDTH-1]) && (diff_s[WIDTH-1] != inp1[WIDTH-1]);
            end
            ALU_SUBU: result_d = diff_s;
            ALU_AND:  result_d = inp1 & inp2;
            ALU_OR:   result_d = inp1 | inp2;
            ALU_XOR:  result_d = inp1 ^ inp2;
            ALU_NOR:  result_d = ~(inp1 | inp2);
            ALU_SLT:  result_d = ($signed(inp1) < $signed(inp2)) ? ONE : '0;
            ALU_SLTU: result_d = (inp1 < inp2) ? ONE : '0;
            ALU_ADDI: begin
                result_d = sumi_s;
                ovf_d    = (inp1[WIDTH-1] == imm_se_s[WIDTH-1]) && (sumi_s[WIDTH-1] != inp1[WIDTH-1]);
            end
            ALU_ADDIU: result_d = sumi_s;
            ALU_SLTI:  result_d = ($signed(inp1) < $signed(imm_se_s)) ? ONE : '0;
            ALU_SLTIU: result_d = (inp1 < imm_se_s) ? ONE : '0;
            ALU_ANDI:  result_d = inp1 & imm_ze_s;
            ALU_ORI:   result_d = inp1 | imm_ze_s;
            ALU_XORI:  result_d = inp1 ^ imm_ze_s;
            ALU_LUI:   result_d = {inp2[15:0], 16'h0000};
            default: begin
                result_d = '0;
                ovf_d    = 1'b0;
            end
        endcase
    end

    // Pipeline boundary: result and flags registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= '0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            out_q  <= result_d;
            zero_q <= (result_d == '0);
            ovf_q  <= ovf_d;
        end
    end

    assign out      = out_q;
    assign zero     = zero_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_mips_alu.sv
module tb_mips_alu;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  opcode = 6'd0;
    logic [5:0]  funct = 6'd0;
    logic [31:0] inp1 = 32'd0;
    logic [31:0] inp2 = 32'd0;
    logic [4:0]  shamt = 5'd0;
    logic [31:0] out;
    logic        zero;
    logic        overflow;

    int n_cmp = 0;
    int n_err = 0;

    mips_alu #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .opcode   (opcode),
        .funct    (funct),
        .inp1     (inp1),
        .inp2     (inp2),
        .shamt    (shamt),
        .out      (out),
        .zero     (zero),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] e_out, input logic e_zero, input logic e_ovf);
        n_cmp++;
        assert (out === e_out) else begin
            n_err++;
            $error("FAIL %s out: got %h expected %h", tag, out, e_out);
        end
        n_cmp++;
        assert (zero === e_zero) else begin
            n_err++;
            $error("FAIL %s zero: got %b expected %b", tag, zero, e_zero);
        end
        n_cmp++;
        assert (overflow === e_ovf) else begin
            n_err++;
            $error("FAIL %s overflow: got %b expected %b", tag, overflow, e_ovf);
        end
    endtask

    // Drive one operation, clock it, and sample 1 time unit after the edge.
    task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh);
        opcode = op; funct = fn; inp1 = a; inp2 = b; shamt = sh;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        @(posedge clk); #1;
        check("reset", 32'h0, 1'b0, 1'b0);
        #6 rst_n = 1'b1;

        run(OP_RTYPE, FN_SLL, 32'hFFFFFFFF, 32'h1, 5'd3);
        check("sll", 32'h8, 1'b0, 1'b0);
        run(OP_RTYPE, FN_ADD, 32'hFFFFFFFF, 32'h3, 5'd0);
        check("add_wrap", 32'h2, 1'b0, 1'b0);
        run(OP_RTYPE, FN_ADD, 32'h7FFFFFFF, 32'h1, 5'd0);
        check("add_ovf", 32'h80000000, 1'b0, 1'b1);
        run(OP_RTYPE, FN_ADDU, 32'h7FFFFFFF, 32'h1, 5'd0);
        check("addu", 32'h80000000, 1'b0, 1'b0);
        run(OP_RTYPE, FN_AND, 32'hFFFFFFFF, 32'h1F, 5'd0);
        check("and", 32'h1F, 1'b0, 1'b0);
        run(OP_RTYPE, FN_SUB, 32'h5, 32'h5, 5'd0);
        check("sub_zero", 32'h0, 1'b1, 1'b0);
        run(OP_RTYPE, FN_SUB, 32'h80000000, 32'h1, 5'd0);
        check("sub_ovf", 32'h7FFFFFFF, 1'b0, 1'b1);
        run(OP_RTYPE, FN_SUBU, 32'h80000000, 32'h1, 5'd0);
        check("subu", 32'h7FFFFFFF, 1'b0, 1'b0);
        run(OP_RTYPE, FN_SRA, 32'h0, 32'h80000000, 5'd31);
        check("sra31", 32'hFFFFFFFF, 1'b0, 1'b0);
        run(OP_RTYPE, FN_SRL, 32'h0, 32'h80000000, 5'd31);
        check("srl31", 32'h1, 1'b0, 1'b0);
        run(OP_RTYPE, FN_SRAV, 32'hFFFFFFE4, 32'hF0000000, 5'd0);
        check("srav", 32'hFF000000, 1'b0, 1'b0);
        run(OP_RTYPE, FN_SLLV, 32'h8, 32'h000000AB, 5'd31);
        check("sllv", 32'h0000AB00, 1'b0, 1'b0);
        run(OP_RTYPE, FN_SRLV, 32'h4, 32'hF0000000, 5'd0);
        check("srlv", 32'h0F000000, 1'b0, 1'b0);
        run(OP_RTYPE, FN_SLL, 32'h0, 32'h12345678, 5'd0);
        check("sll0", 32'h12345678, 1'b0, 1'b0);
        run(OP_RTYPE, FN_SLT, 32'hFFFFFFFF, 32'h1, 5'd0);
        check("slt", 32'h1, 1'b0, 1'b0);
        run(OP_RTYPE, FN_SLTU, 32'hFFFFFFFF, 32'h1, 5'd0);
        check("sltu", 32'h0, 1'b1, 1'b0);
        run(OP_RTYPE, FN_OR, 32'hF0F00000, 32'h00000F0F, 5'd0);
        check("or", 32'hF0F00F0F, 1'b0, 1'b0);
        run(OP_RTYPE, FN_XOR, 32'hFFFF0000, 32'hFF00FF00, 5'd0);
        check("xor", 32'h00FFFF00, 1'b0, 1'b0);
        run(OP_RTYPE, FN_NOR, 32'h0, 32'h0, 5'd0);
        check("nor", 32'hFFFFFFFF, 1'b0, 1'b0);
        run(OP_ADDI, 6'd0, 32'd10, 32'h0000FFFF, 5'd0);
        check("addi", 32'd9, 1'b0, 1'b0);
        run(OP_ADDI, 6'd0, 32'h7FFFFFFF, 32'h00000001, 5'd0);
        check("addi_ovf", 32'h80000000, 1'b0, 1'b1);
        run(OP_ADDIU, 6'd0, 32'h7FFFFFFF, 32'h00000001, 5'd0);
        check("addiu", 32'h80000000, 1'b0, 1'b0);
        run(OP_SLTI, 6'd0, 32'hFFFFFFFE, 32'h0000FFFF, 5'd0);
        check("slti", 32'h1, 1'b0, 1'b0);
        run(OP_SLTIU, 6'd0, 32'h5, 32'h0000FFFF, 5'd0);
        check("sltiu", 32'h1, 1'b0, 1'b0);
        run(OP_ANDI, 6'd0, 32'hFFFFFFFF, 32'hFFFF8000, 5'd0);
        check("andi", 32'h00008000, 1'b0, 1'b0);
        run(OP_ORI, 6'd0, 32'h12340000, 32'hFFFF8001, 5'd0);
        check("ori", 32'h12348001, 1'b0, 1'b0);
        run(OP_XORI, 6'd0, 32'hFFFFFFFF, 32'h0000FFFF, 5'd0);
        check("xori", 32'hFFFF0000, 1'b0, 1'b0);
        run(OP_LUI, 6'd0, 32'hDEADBEEF, 32'h00001234, 5'd0);
        check("lui", 32'h12340000, 1'b0, 1'b0);
        run(6'b111111, 6'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0);
        check("bad_op", 32'h0, 1'b1, 1'b0);
        run(OP_RTYPE, 6'b000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0);
        check("bad_fn", 32'h0, 1'b1, 1'b0);

        // Asynchronous reset mid-operation, with overflow set beforehand
        run(OP_RTYPE, FN_ADD, 32'h7FFFFFFF, 32'h1, 5'd0);
        check("pre_reset", 32'h80000000, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", 32'h0, 1'b0, 1'b0);
        #2 rst_n = 1'b1;
        #1;
        check("reset_hold", 32'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("post_reset", 32'h80000000, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mips_alu.md
Name: mips_alu

Overview:
32-bit MIPS-style integer ALU for the execute stage of the single-cycle/pipelined CPU datapath. Decodes `opcode` (R-type vs I-type) and `funct` and computes arithmetic, logic, shift and compare results. Result and flags are registered, with one cycle of latency, so the block is a clean pipeline boundary.

Parameters:
- WIDTH, 32, datapath width. Only 32 is required to be supported; the shift amount is fixed at 5 bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  6  instruction opcode; 6'b000000 selects R-type, which is decoded by funct.
- funct  in  6  R-type function field; ignored when opcode != 0.
- inp1  in  32  operand A (rs).
- inp2  in  32  operand B (rt); for I-type, the immediate is inp2[15:0].
- shamt  in  5  shift amount for constant shifts.
- out  out  32  registered result.
- zero  out  1  registered; 1 when the result is 0.
- overflow  out  1  registered; signed overflow of add/sub/addi only.

Behaviour:
- Reset: rst_n low asynchronously forces out=0, zero=0, overflow=0. Reset release is synchronous to the next clk edge.
- Latency: inputs sampled every rising edge; result appears one cycle later. No handshake; throughput is 1 op per cycle.
- R-type (opcode 000000), decoded by funct:
  - 000000 sll: inp2 << shamt
  - 000010 srl: inp2 >> shamt (logical)
  - 000011 sra: inp2 >>> shamt (arithmetic)
  - 000100 sllv: inp2 << inp1[4:0]
  - 000110 srlv: inp2 >> inp1[4:0] (logical)
  - 000111 srav: inp2 >>> inp1[4:0] (arithmetic)
  - 100000 add / 100001 addu: inp1+inp2, mod 2^32
  - 100010 sub / 100011 subu: inp1-inp2, mod 2^32
  - 100100 and, 100101 or, 100110 xor, 100111 nor
  - 101010 slt: signed inp1<inp2 gives 1, else 0
  - 101011 sltu: unsigned compare, same result encoding
- I-type, with imm = inp2[15:0]. SE = sign-extend, ZE = zero-extend:
  - 001000 addi / 001001 addiu: inp1+SE(imm)
  - 001010 slti: signed compare against SE(imm)
  - 001011 sltiu: unsigned compare against SE(imm)
  - 001100 andi, 001101 ori, 001110 xori: with ZE(imm)
  - 001111 lui: {imm,16'h0}
- Undefined funct or opcode: out=0, zero=1, overflow=0. This is not an error condition.
- Wrapping and overflow:
  - Arithmetic always wraps; the result is written even when overflow=1.
  - overflow=1 only for add/sub/addi when the operand signs and the result sign disagree per two's-complement rules.
  - overflow is 0 for addu/subu/addiu and for every other operation.
- Shift by 0 passes inp2 unchanged. A shift by 31 is legal; sra by 31 yields all sign bits.
- Compare results are 32'h00000001 or 32'h00000000.
- Simultaneous reset and clock edge: reset wins.

Decomposition:
- Package alu_pkg holds:
  - localparam constants for every funct code (FN_SLL ... FN_SLTU)
  - localparam constants for every opcode (OP_RTYPE, OP_ADDI ... OP_LUI)
  - an enum alu_op_e for the internal decoded operation
- Decode stage: combinational function mapping {opcode, funct} to alu_op_e.
- Sub-module alu_shifter: combinational 32-bit barrel shifter with inputs value, amount[4:0] and mode {LL, RL, RA}. It is instantiated once; amount is muxed between shamt and inp1[4:0].
- Top level: decode, operand extension, compute mux, output/flag registers.

Test Plan:
- Reset check: assert rst_n=0 mid-operation -> out=0, zero=0, overflow=0 immediately, without waiting for a clock. Hold after release until the next edge.
- sll: opcode=0, funct=000000, inp2=32'h1, shamt=3 -> out=32'h8 after one clk. inp1=32'hFFFFFFFF is ignored.
- add wrap: funct=100000, inp1=32'hFFFFFFFF, inp2=32'h3 -> out=32'h2, overflow=0. Then inp1=32'h7FFFFFFF, inp2=32'h1 -> out=32'h80000000, overflow=1. addu with the same operands -> overflow=0.
- and: funct=100100, inp1=32'hFFFFFFFF, inp2=32'h1F -> out=32'h1F. Then sub with inp1=inp2=32'h5 -> out=0, zero=1.
- Shifts and compares:
  - sra with inp2=32'h80000000, shamt=31 -> 32'hFFFFFFFF
  - srl with the same inputs -> 32'h1
  - slt with 32'hFFFFFFFF vs 32'h1 -> 1
  - sltu with the same operands -> 0
- I-type:
  - addi with inp1=10, inp2[15:0]=16'hFFFF -> 9
  - andi with inp1=32'hFFFFFFFF, imm 16'h8000 -> 32'h00008000
  - lui with imm 16'h1234 -> 32'h12340000
  - opcode 6'b111111 -> out=0, zero=1
